// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//
// Contents:
//   state_t     - responder FSM states
//   req_t       - captured load/store request
//   WORD_BYTES  - byte lanes per storage word
//   addr_ok()   - alignment and range check for a byte address
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    // True when addr is word aligned and its word index lies inside the array.
    // The comparison is done on the full word index, so high address bits that
    // do not fit the index field still count as out of range.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] == 2'b00) && (word_idx < depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset; clears every word to zero
//   wr_en    - write strobe, qualified per lane by wr_be
//   wr_idx   - word index written
//   wr_data  - write data
//   wr_be    - byte-lane enables, bit i controls bits [8i+7:8i]
//   rd_en    - read strobe; rd_data is updated on the same edge
//   rd_idx   - word index read
//   rd_data  - registered read data, holds its value until the next rd_en
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [31:0]           wr_data,
    input  logic [WORD_BYTES-1:0] wr_be,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [31:0]           rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < DEPTH_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of a valid/ready load/store port with a
// programmable access latency. One transaction is outstanding at a time.
//
// Ports:
//   clk, reset             - clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready  - request handshake; req_ready is high only when idle
//   req_we                 - 1 = store, 0 = load
//   req_addr               - byte address (must be word aligned and in range)
//   req_wdata, req_be      - store data and byte-lane enables
//   resp_valid/resp_ready  - response handshake
//   resp_rdata             - load data; zero for stores and errors
//   resp_err               - misaligned or out-of-range request
//   ld_count, st_count     - completed non-error loads / stores, wrapping
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] ld_count,
    output logic [15:0] st_count
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q;
    req_t        cur_req;
    logic        accept;
    logic        commit;
    logic        cur_ok;
    logic [IDX_W-1:0] cur_idx;
    logic        resp_err_q;
    logic        resp_ld_q;
    logic [15:0] ld_count_q;
    logic [15:0] st_count_q;
    logic [31:0] arr_rdata;

    assign accept = req_valid && req_ready;

    // With zero latency the commit happens on the acceptance edge, before the
    // request has been captured, so the live inputs are used in IDLE.
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req.we    = req_we;
            cur_req.addr  = req_addr;
            cur_req.wdata = req_wdata;
            cur_req.be    = req_be;
        end
    end

    assign cur_ok  = addr_ok(cur_req.addr, DEPTH_WORDS);
    assign cur_idx = cur_req.addr[IDX_W+1:2];

    // Commit edge is the one entering RESP.
    assign commit = (state_q != RESP) && (state_d == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= cur_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_err_q <= 1'b0;
            resp_ld_q  <= 1'b0;
            ld_count_q <= '0;
            st_count_q <= '0;
        end else if (commit) begin
            resp_err_q <= !cur_ok;
            resp_ld_q  <= cur_ok && !cur_req.we;
            if (cur_ok && !cur_req.we) begin
                ld_count_q <= ld_count_q + 16'd1;
            end
            if (cur_ok && cur_req.we) begin
                st_count_q <= st_count_q + 16'd1;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit && cur_ok && cur_req.we),
        .wr_idx  (cur_idx),
        .wr_data (cur_req.wdata),
        .wr_be   (cur_req.be),
        .rd_en   (commit && cur_ok && !cur_req.we),
        .rd_idx  (cur_idx),
        .rd_data (arr_rdata)
    );

    // Response fields are gated so they read zero outside RESP and for
    // stores/errors, regardless of what the array read register holds.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = (resp_valid && resp_ld_q) ? arr_rdata : 32'd0;
    assign resp_err   = resp_valid && resp_err_q;
    assign ld_count   = ld_count_q;
    assign st_count   = st_count_q;

endmodule
